// File: rtl/in_port_arb.sv
// in_port_arb: round-robin arbiter and read sequencer for the shared input port register bank
module in_port_arb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]   port_data,
  output logic [ADDR_W-1:0]   port_sel,
  output logic                port_en,
  output logic [3:0]          gnt,
  output logic                busy,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic [1:0]          rd_id
);
  typedef enum logic [1:0] {IDLE, SEL, CAP} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, w, idx, id_n;
  logic hit, en_n, vld_n;
  logic [3:0] elig, gnt_n;
  logic [ADDR_W-1:0] sel_n;
  logic [DATA_W-1:0] data_n;
  assign busy = state != IDLE;
  assign elig = req & ~(rd_valid ? 4'b0001 << rd_id : 4'b0000);
  always_comb begin
    w = ptr;
    hit = 1'b0;
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (elig[idx]) begin
        w = idx;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    gnt_n = gnt;
    sel_n = port_sel;
    en_n = port_en;
    vld_n = 1'b0;
    data_n = rd_data;
    id_n = rd_id;
    case (state)
      IDLE: if (hit) begin
        state_n = SEL;
        ptr_n = w + 2'd1;
        gnt_n = 4'b0001 << w;
        sel_n = req_addr[w*ADDR_W +: ADDR_W];
        en_n = 1'b1;
      end
      SEL: state_n = CAP;
      CAP: begin
        state_n = IDLE;
        gnt_n = 4'b0000;
        sel_n = '0;
        en_n = 1'b0;
        vld_n = 1'b1;
        data_n = port_data;
        id_n = ptr - 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 2'd0;
      gnt <= 4'b0000;
      port_sel <= '0;
      port_en <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_id <= 2'd0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      gnt <= gnt_n;
      port_sel <= sel_n;
      port_en <= en_n;
      rd_valid <= vld_n;
      rd_data <= data_n;
      rd_id <= id_n;
    end
  end
endmodule

// File: tb/tb_in_port_arb.sv
// tb_in_port_arb: directed and randomized checks of in_port_arb against a transaction-level model
module tb_in_port_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [7:0] req_addr;
  logic [7:0] port_data;
  logic [1:0] port_sel;
  logic port_en;
  logic [3:0] gnt;
  logic busy;
  logic rd_valid;
  logic [7:0] rd_data;
  logic [1:0] rd_id;
  logic [7:0] bank [4];
  int total = 0;
  int passed = 0;
  int fails = 0;
  int m_phase, m_w, m_addr, m_ptr, m_id;
  logic [7:0] m_data;
  bit m_vld;
  logic [3:0] hold;
  int served[$];
  int lat;
  int fexp[4] = '{0, 2, 0, 0};

  in_port_arb dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .port_data(port_data),
    .port_sel(port_sel), .port_en(port_en), .gnt(gnt), .busy(busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id)
  );

  assign port_data = bank[port_sel];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_w = 0; m_addr = 0; m_ptr = 0; m_id = 0; m_data = 8'h00; m_vld = 1'b0;
  endtask

  task automatic check_outs(input string p);
    chk({p, "gnt"}, 32'(gnt), m_phase != 0 ? 32'(1 << m_w) : 32'd0);
    chk({p, "port_sel"}, 32'(port_sel), m_phase != 0 ? 32'(m_addr) : 32'd0);
    chk({p, "port_en"}, 32'(port_en), 32'(m_phase != 0));
    chk({p, "busy"}, 32'(busy), 32'(m_phase != 0));
    chk({p, "rd_valid"}, 32'(rd_valid), 32'(m_vld));
    chk({p, "rd_data"}, 32'(rd_data), 32'(m_data));
    chk({p, "rd_id"}, 32'(rd_id), 32'(m_id));
  endtask

  // one clock: advance the model from pre-edge inputs, then check at the falling edge
  task automatic cyc();
    int f;
    logic [3:0] e;
    f = -1;
    e = req;
    if (m_phase == 0) begin
      if (m_vld) e[m_id] = 1'b0;
      for (int i = 0; i < 4; i++) if (f < 0 && e[(m_ptr + i) % 4]) f = (m_ptr + i) % 4;
      m_vld = 1'b0;
      if (f >= 0) begin
        m_phase = 1; m_w = f; m_addr = int'(req_addr[f*2 +: 2]); m_ptr = (f + 1) % 4;
      end
    end else if (m_phase == 1) m_phase = 2;
    else begin
      m_phase = 0; m_vld = 1'b1; m_data = bank[m_addr]; m_id = m_w;
    end
    @(posedge clk);
    @(negedge clk);
    check_outs("");
    if (rd_valid === 1'b1) served.push_back(int'(rd_id));
    if (m_vld && !hold[m_id]) req[m_id] = 1'b0;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("rst_");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; req_addr = 8'h00; hold = 4'b0000;
    for (int i = 0; i < 4; i++) bank[i] = 8'h00;
    model_reset();
    #12;
    check_outs("rst_");
    @(negedge clk);
    rst_n = 1'b1;

    bank[2] = 8'hA5; req_addr = 8'b00_00_00_10; req = 4'b0001; lat = 0; served.delete();
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (lat == 0 && rd_valid === 1'b1) lat = i + 1;
    end
    chk("single_lat", 32'(lat), 32'd3);
    chk("single_data", 32'(rd_data), 32'hA5);
    chk("single_n", 32'(served.size()), 32'd1);

    do_reset();
    bank[0] = 8'h10; bank[1] = 8'h21; bank[2] = 8'h32; bank[3] = 8'h43;
    req_addr = {2'd3, 2'd2, 2'd1, 2'd0}; req = 4'b1111; served.delete();
    for (int i = 0; i < 14; i++) cyc();
    chk("all_n", 32'(served.size()), 32'd4);
    for (int i = 0; i < served.size() && i < 4; i++) chk("all_order", 32'(served[i]), 32'(i));

    hold = 4'b0001; req = 4'b0101; served.delete();
    for (int i = 0; i < 18; i++) cyc();
    chk("fair_n", 32'(served.size() >= 4), 32'd1);
    for (int i = 0; i < served.size() && i < 4; i++) chk("fair_order", 32'(served[i]), 32'(fexp[i]));
    hold = 4'b0000; req = 4'b0000;
    for (int i = 0; i < 4; i++) cyc();

    req = 4'b0010; hold = 4'b0010;
    for (int i = 0; i < 10 && rd_valid !== 1'b1; i++) cyc();
    chk("mask_vld", 32'(rd_valid), 32'd1);
    cyc();
    chk("mask_nogrant", 32'(gnt), 32'd0);
    hold = 4'b0000;
    cyc();
    chk("mask_regrant", 32'(gnt), 32'b0010);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) cyc();

    req_addr[7:6] = 2'd1; bank[1] = 8'h5C; req = 4'b1000;
    cyc();
    req = 4'b0000; req_addr[7:6] = 2'd3; bank[3] = 8'hEE;
    cyc();
    cyc();
    chk("drop_vld", 32'(rd_valid), 32'd1);
    chk("drop_id", 32'(rd_id), 32'd3);
    chk("drop_data", 32'(rd_data), 32'h5C);
    cyc();

    req = 4'b0100;
    cyc();
    cyc();
    chk("cap_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("rstcap_");
    @(negedge clk);
    req = 4'b0000; rst_n = 1'b1;
    cyc();
    cyc();
    req = 4'b1010; served.delete();
    for (int i = 0; i < 10; i++) cyc();
    chk("rstcap_n", 32'(served.size() >= 1), 32'd1);
    if (served.size() >= 1) chk("rstcap_first", 32'(served[0]), 32'd1);

    req = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_addr[i*2 +: 2] = 2'($urandom);
        end
      if ($urandom_range(0, 4) == 0) bank[$urandom_range(0, 3)] = 8'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/in_port_arb.md
# in_port_arb

Round-robin arbiter and read sequencer that shares the bank of 8-bit input port registers among four requesters, e.g. the CPU IN-instruction path, the interrupt pin scanner and the debug unit. It picks one requester at a time, drives the port select to the bank, waits for the port register to settle, and captures the byte. It returns the byte to the winner with a one-cycle valid pulse. It sits between the requesters and the input port registers, which update on the falling edge of clk.

## Interface
- DATA_W, 8, port data width
- ADDR_W, 2, port address width (4 ports)
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  per-requester read request, level, held until rd_valid with matching rd_id
- req_addr  in  4*ADDR_W  port address per requester; requester i at bits [i*ADDR_W +: ADDR_W]
- port_data  in  DATA_W  selected input port register output
- port_sel  out  ADDR_W  port address driven to the bank
- port_en  out  1  bank read enable
- gnt  out  4  one-hot grant, held for the whole transaction
- busy  out  1  transaction in progress (state != IDLE)
- rd_valid  out  1  one-cycle pulse: rd_data/rd_id valid
- rd_data  out  DATA_W  captured port byte
- rd_id  out  2  index of the served requester

## Operation
- States:
  - IDLE: arbitrate.
  - SEL: port_sel/port_en driven, settle cycle.
  - CAP: port_data sampled.
- IDLE: if any eligible req bit is set, the winner is registered. gnt[w]=1, port_sel=req_addr[w] and port_en=1 are all registered. Next state SEL.
- SEL -> CAP unconditionally. Outputs held.
- CAP: at the closing edge, rd_data<=port_data, rd_id<=w, rd_valid<=1, and gnt, port_en and port_sel cleared (port_sel returns 0). Next state IDLE.
- Eligibility: in the IDLE cycle where rd_valid=1, req[rd_id] is masked so a requester that has not yet dropped req is not re-served. In all other IDLE cycles every req bit is eligible.
- Round robin: pointer ptr (2 bits) starts at 0. The search order is ptr, ptr+1, ... mod 4. On each grant, ptr<=w+1 mod 4.
- req_addr is sampled only at grant. Later changes have no effect on the running transaction.
- A req drop during SEL/CAP does not abort. The transaction completes and rd_valid still pulses.
- There are no invalid addresses (2^ADDR_W ports).

## Timing
- Reset values:
  - state=IDLE, ptr=0
  - gnt=0, busy=0, port_en=0, port_sel=0
  - rd_valid=0, rd_data=0, rd_id=0
- Reset is asynchronous and takes effect immediately, including mid-SEL or mid-CAP. An aborted transaction produces no rd_valid and no grant remains.
- Latency is counted from the edge that registers the grant (edge 0):
  - gnt/port_en are high for cycles 1–2.
  - port_data is sampled at edge 2.
  - rd_valid is high in cycle 3.
  - For a request seen in IDLE at cycle 0, rd_valid is in cycle 3.
- Back-to-back: the rd_valid IDLE cycle also arbitrates. Peak rate is one read per 3 cycles, and busy drops for exactly one cycle between transactions.
- port_data must be stable one full clk period after port_en rises. The bank's falling-edge update satisfies this.
- rd_valid is always exactly one cycle. rd_data/rd_id hold their values until the next capture.

## Test plan
- Single request: req=0001, addr0=2, port2 data=0xA5. Required: gnt=0001 and port_sel=2 for 2 cycles, then rd_valid=1 with rd_data=0xA5 and rd_id=0 at latency 3.
- Simultaneous requests: req=1111 held until each requester's rd_valid, addrs 0..3, ports hold 0x10,0x21,0x32,0x43. Required: served order 0,1,2,3 with matching data, reads 3 cycles apart.
- Fairness: req0 held high permanently and req2 raised once. Required: ids 0,2,0,0,... with req2 served within 2 transactions, and req0 never served twice in a row while req2 is pending.
- Mask: req1 held high one cycle past its rd_valid, no other requests. Required: no grant during the rd_valid cycle, then req1 is re-granted only on the following cycle.
- Drop / address change mid-transaction: req3 dropped and addr3 changed during SEL. Required: rd_valid still pulses with rd_id=3 and data from the originally sampled port.
- Reset mid-CAP: rst_n pulled low during CAP. Required: all outputs 0 immediately, no rd_valid after release, and ptr=0 so a subsequent req=1010 serves requester 1 first.
